// File: rtl/reg_writeback_stage.sv
// Writeback stage: a W pipeline register, the register-file write port, write-through
// bypass for the two decode read ports, and a retired-instruction counter.

module reg_writeback_bypass #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      a,
  input  logic [XLEN-1:0] rf,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] byp
);
  always_comb begin
    byp = rf;
    if (a == 5'd0)          byp = '0;
    else if (we && a == wa) byp = wd;
  end
endmodule

module reg_writeback_stage #(
  parameter int XLEN = 32,
  parameter int CNTW = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_m,
  input  logic            reg_write_m,
  input  logic [1:0]      result_src_m,
  input  logic [4:0]      rd_m,
  input  logic [XLEN-1:0] alu_result_m,
  input  logic [XLEN-1:0] read_data_m,
  input  logic [XLEN-1:0] pc_plus4_m,
  input  logic [XLEN-1:0] imm_ext_m,
  input  logic            stall_w,
  input  logic            flush_w,
  input  logic [4:0]      a1,
  input  logic [4:0]      a2,
  input  logic [XLEN-1:0] rd1_rf,
  input  logic [XLEN-1:0] rd2_rf,
  output logic [4:0]      a3,
  output logic [XLEN-1:0] wd3,
  output logic            we3,
  output logic [XLEN-1:0] rd1_byp,
  output logic [XLEN-1:0] rd2_byp,
  output logic            valid_w,
  output logic [CNTW-1:0] instret
);
  localparam int NUM_PORTS = 2;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [1:0]      src;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] ld;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] imm;
    logic            done;
  } wstage_t;

  wstage_t         w_q, w_d;
  logic [CNTW-1:0] instret_q, instret_d;
  logic            capture;

  assign capture = ~stall_w & ~flush_w;

  // done marks a stalled instruction that has already written, so it writes only once.
  always_comb begin
    w_d = w_q;
    if (flush_w) begin
      w_d.valid     = 1'b0;
      w_d.reg_write = 1'b0;
      w_d.done      = 1'b0;
    end else if (!stall_w) begin
      w_d.valid     = valid_m;
      w_d.reg_write = reg_write_m;
      w_d.src       = result_src_m;
      w_d.rd        = rd_m;
      w_d.alu       = alu_result_m;
      w_d.ld        = read_data_m;
      w_d.pc4       = pc_plus4_m;
      w_d.imm       = imm_ext_m;
      w_d.done      = 1'b0;
    end else begin
      w_d.done      = w_q.done | we3;
    end
  end

  always_comb begin
    instret_d = instret_q + CNTW'(valid_m & capture);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q       <= '0;
      instret_q <= '0;
    end else begin
      w_q       <= w_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    unique case (w_q.src)
      2'b00:   wd3 = w_q.alu;
      2'b01:   wd3 = w_q.ld;
      2'b10:   wd3 = w_q.pc4;
      default: wd3 = w_q.imm;
    endcase
  end

  assign a3      = w_q.rd;
  assign we3     = w_q.valid & w_q.reg_write & (w_q.rd != 5'd0) & ~w_q.done;
  assign valid_w = w_q.valid;
  assign instret = instret_q;

  logic [NUM_PORTS-1:0][4:0]      rd_addr;
  logic [NUM_PORTS-1:0][XLEN-1:0] rf_data;
  logic [NUM_PORTS-1:0][XLEN-1:0] byp;

  assign rd_addr = {a2, a1};
  assign rf_data = {rd2_rf, rd1_rf};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_byp
    reg_writeback_bypass #(.XLEN(XLEN)) u_byp (
      .a  (rd_addr[p]),
      .rf (rf_data[p]),
      .we (we3),
      .wa (a3),
      .wd (wd3),
      .byp(byp[p])
    );
  end

  assign rd1_byp = byp[0];
  assign rd2_byp = byp[1];
endmodule

// File: tb/tb_reg_writeback_stage.sv
// Directed and randomized checks of reg_writeback_stage against a transaction-level model
// that tracks the current W instruction, whether it has written yet, and a retire count.

module tb_reg_writeback_stage;
  localparam int XLEN = 32;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_m, reg_write_m, stall_w, flush_w;
  logic [1:0]      result_src_m;
  logic [4:0]      rd_m, a1, a2;
  logic [XLEN-1:0] alu_result_m, read_data_m, pc_plus4_m, imm_ext_m, rd1_rf, rd2_rf;
  logic [4:0]      a3;
  logic [XLEN-1:0] wd3, rd1_byp, rd2_byp;
  logic            we3, valid_w;
  logic [CNTW-1:0] instret;

  reg_writeback_stage #(.XLEN(XLEN), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .valid_m(valid_m), .reg_write_m(reg_write_m),
    .result_src_m(result_src_m), .rd_m(rd_m), .alu_result_m(alu_result_m),
    .read_data_m(read_data_m), .pc_plus4_m(pc_plus4_m), .imm_ext_m(imm_ext_m),
    .stall_w(stall_w), .flush_w(flush_w), .a1(a1), .a2(a2), .rd1_rf(rd1_rf),
    .rd2_rf(rd2_rf), .a3(a3), .wd3(wd3), .we3(we3), .rd1_byp(rd1_byp),
    .rd2_byp(rd2_byp), .valid_w(valid_w), .instret(instret)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: the instruction sitting in W, its selected result, and whether it has written.
  bit              m_valid, m_write, m_written, m_known;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_wd;
  int unsigned     m_retired;

  function automatic bit m_we();
    return m_valid && m_write && (m_rd != 0) && !m_written;
  endfunction

  function automatic logic [XLEN-1:0] m_byp(input logic [4:0] a, input logic [XLEN-1:0] rf);
    if (a == 0) return '0;
    if (m_we() && a == m_rd) return m_wd;
    return rf;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_write = 0; m_written = 0; m_known = 1;
    m_rd = 0; m_wd = 0; m_retired = 0;
  endtask

  task automatic model_edge();
    if (!rst) begin
      model_reset();
    end else if (flush_w) begin
      m_valid = 0; m_write = 0; m_written = 0; m_known = 0;
    end else if (stall_w) begin
      if (m_we()) m_written = 1;
    end else begin
      m_valid = valid_m; m_write = reg_write_m; m_rd = rd_m; m_written = 0; m_known = 1;
      case (result_src_m)
        2'd0: m_wd = alu_result_m;
        2'd1: m_wd = read_data_m;
        2'd2: m_wd = pc_plus4_m;
        default: m_wd = imm_ext_m;
      endcase
      if (valid_m) m_retired = (m_retired + 1) % (1 << CNTW);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid_w"}, 64'(valid_w), 64'(m_valid));
    chk({tag, ".we3"}, 64'(we3), 64'(m_we()));
    chk({tag, ".instret"}, 64'(instret), 64'(m_retired));
    if (m_known) begin
      chk({tag, ".a3"}, 64'(a3), 64'(m_rd));
      chk({tag, ".wd3"}, 64'(wd3), 64'(m_wd));
    end
    chk({tag, ".rd1_byp"}, 64'(rd1_byp), 64'(m_byp(a1, rd1_rf)));
    chk({tag, ".rd2_byp"}, 64'(rd2_byp), 64'(m_byp(a2, rd2_rf)));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_m(input bit v, input bit rw, input logic [1:0] src, input logic [4:0] rd,
                         input logic [XLEN-1:0] alu, input logic [XLEN-1:0] ld);
    valid_m = v; reg_write_m = rw; result_src_m = src; rd_m = rd;
    alu_result_m = alu; read_data_m = ld;
    pc_plus4_m = 32'h0000_1004; imm_ext_m = 32'h0000_0ABC;
  endtask

  initial begin
    int unsigned base;
    rst = 1'b1;
    drive_m(0, 0, 2'd0, 5'd0, '0, '0);
    stall_w = 0; flush_w = 0; a1 = 0; a2 = 0;
    rd1_rf = 32'h1111_1111; rd2_rf = 32'h2222_2222;
    #1 rst = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    chk("reset.wd3_zero", 64'(wd3), 64'd0);

    // Inputs present while in reset must not be captured.
    drive_m(1, 1, 2'd0, 5'd9, 32'h55, '0);
    tick();
    check_all("reset_hold");
    rst = 1'b1;

    // ALU writeback and same-cycle bypass on port 1.
    drive_m(1, 1, 2'd0, 5'd5, 32'h2A, '0);
    tick();
    drive_m(0, 0, 2'd0, 5'd0, '0, '0);
    a1 = 5; a2 = 6;
    #1;
    check_all("alu");
    chk("alu.we3_lit", 64'(we3), 64'd1);
    chk("alu.byp_lit", 64'(rd1_byp), 64'h2A);
    chk("alu.instret_lit", 64'(instret), 64'd1);

    // Load-data writeback, bypass on port 2 only when address matches.
    drive_m(1, 1, 2'd1, 5'd7, 32'h0, 32'hDEADBEEF);
    tick();
    a1 = 1; a2 = 7;
    #1;
    check_all("load");
    chk("load.byp_lit", 64'(rd2_byp), 64'hDEADBEEF);
    a2 = 8;
    #1;
    chk("load.nobyp_lit", 64'(rd2_byp), 64'h2222_2222);

    // Write to x0: no enable, no bypass, still retires.
    base = m_retired;
    drive_m(1, 1, 2'd0, 5'd0, 32'hFF, '0);
    tick();
    a1 = 0; a2 = 0;
    #1;
    check_all("x0");
    chk("x0.we3_lit", 64'(we3), 64'd0);
    chk("x0.byp_lit", 64'(rd1_byp), 64'd0);
    chk("x0.instret_lit", 64'(instret), 64'((base + 1) % 16));

    // Stalled instruction writes exactly once.
    base = m_retired;
    drive_m(1, 1, 2'd0, 5'd3, 32'h33, '0);
    tick();
    stall_w = 1;
    drive_m(1, 1, 2'd0, 5'd12, 32'h99, '0);
    a1 = 3;
    #1;
    check_all("stall0");
    chk("stall0.we3_lit", 64'(we3), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      #1;
      check_all($sformatf("stall%0d", i));
      chk($sformatf("stall%0d.we3_lit", i), 64'(we3), 64'd0);
      chk($sformatf("stall%0d.a3_lit", i), 64'(a3), 64'd3);
      chk($sformatf("stall%0d.wd3_lit", i), 64'(wd3), 64'h33);
    end
    chk("stall.instret_lit", 64'(instret), 64'((base + 1) % 16));

    // Flush beats stall.
    base = m_retired;
    flush_w = 1;
    tick();
    stall_w = 0; flush_w = 0;
    drive_m(0, 0, 2'd0, 5'd0, '0, '0);
    #1;
    check_all("flush");
    chk("flush.valid_lit", 64'(valid_w), 64'd0);
    chk("flush.instret_lit", 64'(instret), 64'(base));

    // Asynchronous reset mid-cycle while writing.
    drive_m(1, 1, 2'd2, 5'd10, '0, '0);
    tick();
    drive_m(1, 1, 2'd3, 5'd11, '0, '0);
    a1 = 10;
    #1;
    check_all("prerst");
    #1 rst = 1'b0;
    model_reset();
    #1;
    check_all("midrst");
    chk("midrst.we3_lit", 64'(we3), 64'd0);
    chk("midrst.a3_lit", 64'(a3), 64'd0);
    chk("midrst.wd3_lit", 64'(wd3), 64'd0);
    chk("midrst.instret_lit", 64'(instret), 64'd0);
    tick();
    check_all("midrst_edge");
    rst = 1'b1;
    tick();
    check_all("post_rst");
    chk("post_rst.instret_lit", 64'(instret), 64'd1);

    // Randomized traffic, including counter wrap and occasional reset.
    for (int c = 0; c < 400; c++) begin
      drive_m($urandom_range(0, 3) != 0, $urandom_range(0, 1), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
              $urandom, $urandom);
      pc_plus4_m = $urandom; imm_ext_m = $urandom;
      stall_w = ($urandom_range(0, 3) == 0);
      flush_w = ($urandom_range(0, 9) == 0);
      a1 = ($urandom_range(0, 1) != 0) ? m_rd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 1) != 0) ? m_rd : 5'($urandom_range(0, 31));
      rd1_rf = $urandom; rd2_rf = $urandom;
      #1;
      check_all($sformatf("rnd%0d", c));
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b0;
        model_reset();
        #1;
        check_all($sformatf("rnd%0d.rst", c));
        tick();
        rst = 1'b1;
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
